rr_request_arbiter: RTL and testbench
=====================================

// Module: rr_request_arbiter
// PURPOSE
//  - Shares one downstream resource (e.g. a bus or datapath slot) among 4 requesters.
//  - Uses round-robin arbitration with a registered one-hot grant, an encoded index and a done/release handshake.
//  - Sits in front of the 4-input priority encoding stage, turning raw request lines into a fair, held, sequenced grant.
// PARAMETERS
//  - N_REQ     4   number of requesters; fixed at 4, with gnt_idx 2 bits wide
//  - IDX_W     2   width of gnt_idx (clog2(N_REQ))
//  - MAX_HOLD  16  cycles a grant may stay in GRANT before a forced release (ARB_TIMEOUT_EN only)
//  - TO_W      5   hold-counter width; must satisfy 2**TO_W > MAX_HOLD
// PORTS
//  - clk        in   1      single clock, rising edge
//  - rst_n      in   1      asynchronous, active-low reset
//  - req        in   4      request per requester; held high until served
//  - done       in   1      current owner finished; sampled only in GRANT
//  - gnt        out  4      one-hot grant, registered; all zero when no owner
//  - gnt_idx    out  2      binary index of current owner; holds last owner when gnt_valid=0
//  - gnt_valid  out  1      high exactly when gnt != 0
//  - busy       out  1      high in GRANT and RELEASE
//  - timeout    out  1      1-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE; gnt=0, gnt_idx=0, gnt_valid=0, busy=0, timeout=0.
//    - last_ptr=3, so req[0] has first priority after reset.
//  - Round-robin pick: search order is last_ptr+1, +2, +3, +4 (mod 4); the first set req bit wins.
//  - FSM states: IDLE, GRANT, RELEASE.
//    - IDLE: if |req at edge t, then at t+1 the state is GRANT with the winner on gnt/gnt_idx and gnt_valid=1.
//      - Request-to-grant latency is 1 cycle.
//    - GRANT: the grant is held while req[gnt_idx]=1 and done=0.
//      - Release condition: done=1, OR req[gnt_idx]=0 (abandon).
//      - On release: next state RELEASE, gnt=0, gnt_valid=0, last_ptr<=gnt_idx.
//      - done and req drop in the same cycle count as a single release.
//    - RELEASE: exactly one dead cycle with gnt=0 and busy=1.
//      - If |req at this edge, go straight to GRANT with a new pick using the updated last_ptr; else go to IDLE.
//      - Handover gap is therefore exactly 1 cycle; the same requester may be regranted if it is the only one asking.
//  - done is ignored in IDLE and RELEASE. Requests other than the owner's never disturb a held grant.
//  - Reset mid-GRANT clears the grant immediately (asynchronously); no release cycle and no timeout pulse.
//  - gnt_idx changes only on a new grant. gnt is never multi-hot and never switches owner without an intervening all-zero cycle.
// CONFIGURATION
//  - Macro: ARB_TIMEOUT_EN.
//    - Defined:
//      - A TO_W-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
//      - When it reaches MAX_HOLD with no release, the arbiter forces RELEASE: timeout=1 for that one cycle and last_ptr<=gnt_idx.
//      - done on the same cycle as the timeout is treated as a normal release, with timeout=0.
//    - Undefined:
//      - No counter is built and timeout is tied to 1'b0.
//      - A grant is held indefinitely until done or request drop.
// STRUCTURE
//  - Package arb_pkg:
//    - N_REQ and IDX_W constants.
//    - State encoding: ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2; 2'd3 is illegal and recovers to IDLE.
//    - Default MAX_HOLD.
//  - Sub-module rr_pick: purely combinational. Inputs req[3:0] and last_ptr[1:0]; outputs pick_idx[1:0] and pick_any.
//  - Top level: FSM, output registers, last_ptr, and the optional hold counter.
// TESTING
//  - Reset, idle:
//    - rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, busy=0.
//    - Release reset, req=4'b1111 -> next cycle gnt=4'b0001, gnt_idx=0.
//  - Rotation with all requesters active:
//    - Hold req=4'b1111 and pulse done on every grant.
//    - Expect grant order idx 0,1,2,3,0 with exactly one gnt=0 cycle between grants.
//  - Lone requester:
//    - req=4'b0100, pulse done.
//    - Expect gnt=4'b0100, then 1 cycle of 0, then 4'b0100 again with gnt_idx=2.
//  - Abandon:
//    - Owner idx 1 drops req[1] without done while req=4'b1000 is pending.
//    - Expect RELEASE, then gnt=4'b1000.
//  - Reset mid-grant:
//    - During GRANT of idx 2, assert rst_n=0 between clock edges.
//    - Expect gnt=0 immediately; after reset release with req=4'b0100, expect gnt=4'b0100.
//  - Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):
//    - req=4'b0011, never assert done.
//    - Expect idx 0 granted for 4 cycles, a timeout pulse, 1 dead cycle, then gnt=4'b0010.
//    - Without the macro: idx 0 held for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_request_arbiter_pkg.sv
// Shared constants and state encoding for the 4-way round-robin request arbiter.
package arb_pkg;
  localparam int N_REQ        = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 16;
  localparam int TO_W_DEF     = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_vec_t idx2onehot(idx_t i);
    return req_vec_t'(1) << i;
  endfunction
endpackage

// File: rtl/rr_request_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_request_arbiter_if;
  import arb_pkg::*;
  req_vec_t req;
  logic     done;
  req_vec_t gnt;
  idx_t     gnt_idx;
  logic     gnt_valid;
  logic     busy;
  logic     timeout;

  modport master (output req, done, input gnt, gnt_idx, gnt_valid, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, busy, timeout);
endinterface

// File: rtl/rr_request_arbiter_pick.sv
// Combinational round-robin pick: first set req bit after last_ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  idx_t     last_ptr,
  output idx_t     pick_idx,
  output logic     pick_any
);
  logic [N_REQ-1:0][IDX_W-1:0] cand;
  logic [N_REQ-1:0]            hit;

  // cand[k] is the (k+1)-th requester in search order after last_ptr
  for (genvar k = 0; k < N_REQ; k++) begin : g_cand
    assign cand[k] = last_ptr + IDX_W'(k + 1);
    assign hit[k]  = req[cand[k]];
  end

  always_comb begin
    pick_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (hit[k]) pick_idx = cand[k];
  end

  assign pick_any = |req;
endmodule

// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter FSM with registered one-hot grant and done/release handshake.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_request_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int TO_W     = TO_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_request_arbiter_if.slave  bus
);
  logic [1:0] state;
  req_vec_t   gnt_q;
  idx_t       gnt_idx_q, last_ptr;
  idx_t       pick_idx;
  logic       pick_any;
  logic       rel_norm, force_rel, timeout_q;

  rr_pick u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  assign rel_norm = bus.done | ~bus.req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] hold_cnt;

  // Counter sits at 0 outside GRANT, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                hold_cnt <= '0;
    else if (state != ST_GRANT) hold_cnt <= '0;
    else                       hold_cnt <= hold_cnt + 1'b1;
  end

  assign force_rel = (state == ST_GRANT) && (hold_cnt == TO_W'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      last_ptr  <= idx_t'(N_REQ - 1);
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE, ST_RELEASE: begin
          if (pick_any) begin
            state     <= ST_GRANT;
            gnt_q     <= idx2onehot(pick_idx);
            gnt_idx_q <= pick_idx;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (rel_norm || force_rel) begin
            state     <= ST_RELEASE;
            gnt_q     <= '0;
            last_ptr  <= gnt_idx_q;
            timeout_q <= force_rel & ~rel_norm;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.busy      = (state == ST_GRANT) || (state == ST_RELEASE);
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_rr_request_arbiter.sv
// Directed + random bench for rr_request_arbiter against an owner/phase reference model.
module tb_rr_request_arbiter;
  import arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int MH    = 4;
  localparam int TW    = 3;
`else
  localparam bit TO_EN = 1'b0;
  localparam int MH    = 16;
  localparam int TW    = 5;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_request_arbiter_if bus();

  rr_request_arbiter #(.MAX_HOLD(MH), .TO_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: who owns the resource (-1 none), whether we are in the dead cycle,
  // who was served last, and how many cycles the current grant has been visible.
  int m_owner, m_last, m_idx, m_held;
  bit m_rel, m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1; m_last = 3; m_idx = 0; m_held = 0; m_rel = 0; m_to = 0;
  endtask

  task automatic m_step(input logic [3:0] r, input logic d);
    bit drop, expire;
    m_to = 0;
    if (m_owner >= 0) begin
      drop   = !r[m_owner];
      expire = TO_EN && (m_held >= MH);
      if (d || drop || expire) begin
        m_to    = expire && !d && !drop;
        m_last  = m_owner;
        m_owner = -1;
        m_rel   = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_rel = 0;
      for (int k = 1; k <= 4; k++)
        if (m_owner < 0 && r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
      if (m_owner >= 0) begin
        m_idx  = m_owner;
        m_held = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt",       32'(bus.gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("gnt_idx",   32'(bus.gnt_idx),   32'(m_idx));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    chk("busy",      32'(bus.busy),      32'((m_owner >= 0) || m_rel));
    chk("timeout",   32'(bus.timeout),   32'(m_to));
    chk("onehot0",   32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic tick(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    m_step(r, d);
    #1;
    check_outputs();
  endtask

  initial begin
    int to_seen;
    rst_n    = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    m_reset();
    #12;
    check_outputs();
    chk("reset_gnt", 32'(bus.gnt), 32'd0);

    // first grant after reset goes to requester 0
    @(negedge clk) rst_n = 1'b1;
    tick(4'b1111, 1'b0);
    chk("first_gnt", 32'(bus.gnt), 32'b0001);

    // rotation 0 -> 1 -> 2 -> 3 -> 0 with one dead cycle each
    for (int g = 1; g <= 4; g++) begin
      tick(4'b1111, 1'b1);
      chk("rot_gap", 32'(bus.gnt), 32'd0);
      tick(4'b1111, 1'b0);
      chk("rot_idx", 32'(bus.gnt_idx), 32'(g % 4));
    end
    tick(4'b1111, 1'b1);
    tick(4'b0000, 1'b0);

    // lone requester is regranted after a single gap
    tick(4'b0100, 1'b0);
    chk("lone_gnt", 32'(bus.gnt), 32'b0100);
    tick(4'b0100, 1'b1);
    chk("lone_gap", 32'(bus.gnt), 32'd0);
    tick(4'b0100, 1'b0);
    chk("lone_regnt", 32'(bus.gnt), 32'b0100);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);

    // abandon: owner 1 drops its request while 3 waits
    tick(4'b0010, 1'b0);
    chk("ab_idx", 32'(bus.gnt_idx), 32'd1);
    tick(4'b1010, 1'b0);
    tick(4'b1000, 1'b0);
    chk("ab_rel_busy", 32'(bus.busy), 32'd1);
    chk("ab_rel_gnt",  32'(bus.gnt),  32'd0);
    tick(4'b1000, 1'b0);
    chk("ab_new_gnt", 32'(bus.gnt), 32'b1000);

    // asynchronous reset in the middle of a grant to requester 2
    tick(4'b1000, 1'b1);
    tick(4'b0100, 1'b0);
    chk("mid_idx", 32'(bus.gnt_idx), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_gnt",  32'(bus.gnt),  32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_outputs();
    @(negedge clk) rst_n = 1'b1;
    tick(4'b0100, 1'b0);
    chk("post_rst_gnt", 32'(bus.gnt), 32'b0100);
    tick(4'b0100, 1'b1);
    tick(4'b0000, 1'b0);

    // hold without done: forced release only when the timeout feature is built
    to_seen = 0;
    for (int i = 0; i < (TO_EN ? 2 * MH + 4 : 100); i++) begin
      tick(4'b0011, 1'b0);
      if (bus.timeout) to_seen++;
    end
    chk("hold_timeouts", 32'(to_seen), TO_EN ? 32'd2 : 32'd0);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++)
      tick(4'($urandom), ($urandom_range(0, 3) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
